// File: rtl/text_line_controller.sv
// text_line_controller: a 16-cell text line overlay for a pixel stream.
// The block keeps a 16 x 7-bit character buffer that is edited by commands
// (PUT, BACKSPACE, CLEAR, SET_CURSOR). It renders the buffer as a 128x16 px
// line at a per-frame origin through an external combinational CharRom, and
// can draw a blinking underline cursor.
//
// Ports:
//   i_clk, i_rst_n                clock, asynchronous active-low reset
//   i_wr_valid / o_wr_ready       command handshake (accept on valid & ready)
//   i_wr_cmd, i_wr_char           command code and character / target cell
//   i_frame_start                 latches i_pos_x / i_pos_y as the line origin
//   i_pixel_x, i_pixel_y          current scan position, one pixel per cycle
//   o_rom_char, o_rom_row         CharRom address (registered)
//   i_rom_line                    CharRom glyph row, bit 7 = leftmost pixel
//   o_text_bit_on                 foreground pixel, 2 cycles after pixel_x/y
//   o_cursor_pos                  current cursor cell
//   o_busy                        high while the CLEAR sweep runs
module text_line_controller #(
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter bit          CURSOR_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [1:0] i_wr_cmd,
  input  logic [6:0] i_wr_char,
  input  logic       i_frame_start,
  input  logic [9:0] i_pos_x,
  input  logic [9:0] i_pos_y,
  input  logic [9:0] i_pixel_x,
  input  logic [9:0] i_pixel_y,
  output logic [6:0] o_rom_char,
  output logic [3:0] o_rom_row,
  input  logic [7:0] i_rom_line,
  output logic       o_text_bit_on,
  output logic [3:0] o_cursor_pos,
  output logic       o_busy
);

  localparam int unsigned CELLS      = 16;
  localparam int unsigned CHAR_W     = 7;
  localparam int unsigned CELL_W     = 4;
  localparam int unsigned COORD_W    = 10;
  localparam int unsigned BLINK_W    = 26;
  localparam int unsigned LINE_PX    = 128;
  localparam int unsigned LINE_ROWS  = 16;

  localparam logic [CHAR_W-1:0] SPACE     = 7'h20;
  localparam logic [1:0]        CMD_PUT   = 2'b00;
  localparam logic [1:0]        CMD_BKSP  = 2'b01;
  localparam logic [1:0]        CMD_CLEAR = 2'b10;
  localparam logic [1:0]        CMD_SETC  = 2'b11;

  typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CHAR_W-1:0]   r_buf [CELLS];
  logic [CELL_W-1:0]   r_cursor;
  logic [CELL_W-1:0]   w_cursor_nxt;
  logic [CELL_W-1:0]   r_clr_cnt;
  logic [CELL_W-1:0]   w_clr_nxt;
  logic                w_we;
  logic [CELL_W-1:0]   w_waddr;
  logic [CHAR_W-1:0]   w_wdata;
  logic                r_wr_ready;
  logic                r_busy;

  logic [COORD_W-1:0]  r_ox;
  logic [COORD_W-1:0]  r_oy;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink;

  logic [COORD_W:0]    w_x_end;
  logic [COORD_W:0]    w_y_end;
  logic                w_in_area;
  logic [6:0]          w_dx;
  logic [3:0]          w_dy;
  logic [CELL_W-1:0]   w_cell;
  logic                r_in_area;
  logic [CELL_W-1:0]   r_cell;
  logic [2:0]          r_bit;
  logic                w_cur_on;
  logic                w_glyph_bit;

  // Command decode and CLEAR sweep; single buffer write port.
  always_comb begin
    w_state_nxt  = r_state;
    w_cursor_nxt = r_cursor;
    w_clr_nxt    = r_clr_cnt;
    w_we         = 1'b0;
    w_waddr      = r_cursor;
    w_wdata      = i_wr_char;
    case (r_state)
      ST_IDLE: begin
        if (i_wr_valid) begin
          case (i_wr_cmd)
            CMD_PUT: begin
              w_we = 1'b1;
              if (r_cursor != 4'hF) w_cursor_nxt = r_cursor + 4'd1;
            end
            CMD_BKSP: begin
              if (r_cursor != 4'h0) begin
                w_cursor_nxt = r_cursor - 4'd1;
                w_we         = 1'b1;
                w_waddr      = r_cursor - 4'd1;
                w_wdata      = SPACE;
              end
            end
            CMD_CLEAR: begin
              w_cursor_nxt = 4'h0;
              w_clr_nxt    = 4'h0;
              w_state_nxt  = ST_CLEAR;
            end
            CMD_SETC: w_cursor_nxt = i_wr_char[3:0];
            default: ;
          endcase
        end
      end
      ST_CLEAR: begin
        w_we      = 1'b1;
        w_waddr   = r_clr_cnt;
        w_wdata   = SPACE;
        w_clr_nxt = r_clr_cnt + 4'd1;
        if (r_clr_cnt == 4'hF) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control state; ready/busy are registered copies of the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cursor   <= '0;
      r_clr_cnt  <= '0;
      r_wr_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cursor   <= w_cursor_nxt;
      r_clr_cnt  <= w_clr_nxt;
      r_wr_ready <= (w_state_nxt == ST_IDLE);
      r_busy     <= (w_state_nxt == ST_CLEAR);
    end
  end

  // Character buffer; reset fills every cell with a space.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(CELLS); i++) r_buf[i] <= SPACE;
    end else if (w_we) begin
      r_buf[w_waddr] <= w_wdata;
    end
  end

  // Line origin, only updated at frame start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ox <= '0;
      r_oy <= '0;
    end else if (i_frame_start) begin
      r_ox <= i_pos_x;
      r_oy <= i_pos_y;
    end
  end

  // Cursor blink: toggles every BLINK_DIV cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  // Stage 1 address generation; upper bounds are 11 bits so they never wrap.
  assign w_x_end   = (COORD_W+1)'(r_ox) + (COORD_W+1)'(LINE_PX);
  assign w_y_end   = (COORD_W+1)'(r_oy) + (COORD_W+1)'(LINE_ROWS);
  assign w_in_area = (i_pixel_x >= r_ox) && ((COORD_W+1)'(i_pixel_x) < w_x_end) &&
                     (i_pixel_y >= r_oy) && ((COORD_W+1)'(i_pixel_y) < w_y_end);
  assign w_dx      = 7'(i_pixel_x - r_ox);
  assign w_dy      = 4'(i_pixel_y - r_oy);
  assign w_cell    = w_dx[6:3];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_area  <= 1'b0;
      r_cell     <= '0;
      r_bit      <= '0;
      o_rom_char <= SPACE;
      o_rom_row  <= '0;
    end else begin
      r_in_area  <= w_in_area;
      r_cell     <= w_cell;
      r_bit      <= w_dx[2:0];
      o_rom_char <= r_buf[w_cell];
      o_rom_row  <= w_dy;
    end
  end

  // Stage 2 pixel select; cursor is an underline on the last glyph row.
  assign w_glyph_bit = i_rom_line[3'd7 - r_bit];
  assign w_cur_on    = CURSOR_EN && r_blink && (r_cell == r_cursor) && (o_rom_row == 4'hF);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_text_bit_on <= 1'b0;
    end else begin
      o_text_bit_on <= r_in_area & (w_glyph_bit | w_cur_on);
    end
  end

  assign o_wr_ready   = r_wr_ready;
  assign o_busy       = r_busy;
  assign o_cursor_pos = r_cursor;

endmodule

// File: tb/tb_text_line_controller.sv
// Bench for text_line_controller: directed table vectors plus hand sequences.
// A tiny CharRom model supplies glyphs: space is blank, any other code c on
// row r gives {1'b1, c} ^ r, so bit 7 (leftmost pixel) is always lit.
module tb_text_line_controller;

  localparam int unsigned BLINK_DIV = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_cmd;
  logic [6:0] wr_char;
  logic       frame_start;
  logic [9:0] pos_x, pos_y, pixel_x, pixel_y;
  logic [6:0] rom_char;
  logic [3:0] rom_row;
  logic [7:0] rom_line;
  logic       text_bit_on;
  logic [3:0] cursor_pos;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  text_line_controller #(.BLINK_DIV(BLINK_DIV), .CURSOR_EN(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_cmd(wr_cmd), .i_wr_char(wr_char),
    .i_frame_start(frame_start), .i_pos_x(pos_x), .i_pos_y(pos_y),
    .i_pixel_x(pixel_x), .i_pixel_y(pixel_y),
    .o_rom_char(rom_char), .o_rom_row(rom_row), .i_rom_line(rom_line),
    .o_text_bit_on(text_bit_on), .o_cursor_pos(cursor_pos), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input logic [6:0] c, input logic [3:0] r);
    return (c == 7'h20) ? 8'h00 : ({1'b1, c} ^ {4'h0, r});
  endfunction

  always_comb rom_line = glyph(rom_char, rom_row);

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic [6:0] exp_char;
    logic [3:0] exp_row;
    logic       exp_on;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] cmd, input logic [6:0] ch);
    bit ok = 1'b0;
    wr_valid = 1'b1;
    wr_cmd   = cmd;
    wr_char  = ch;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (wr_ready) ok = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic frame(input logic [9:0] x, input logic [9:0] y);
    pos_x = x;
    pos_y = y;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic render(input string nm, input logic [9:0] px, input logic [9:0] py,
                        input logic [6:0] ec, input logic [3:0] er, input logic eo);
    pixel_x = px;
    pixel_y = py;
    tick();
    chk({nm, "_char"}, 32'(rom_char), 32'(ec));
    chk({nm, "_row"}, 32'(rom_row), 32'(er));
    tick();
    chk({nm, "_on"}, 32'(text_bit_on), 32'(eo));
  endtask

  task automatic hold_count(input logic [9:0] px, input logic [9:0] py, input int n,
                            output int ones);
    ones = 0;
    pixel_x = px;
    pixel_y = py;
    tick();
    tick();
    for (int k = 0; k < n; k++) begin
      if (text_bit_on) ones++;
      tick();
    end
  endtask

  initial begin
    int ones;

    vecs[0]  = '{10'd100, 10'd50, 7'h41, 4'd0,  1'b1};
    vecs[1]  = '{10'd101, 10'd50, 7'h41, 4'd0,  1'b1};
    vecs[2]  = '{10'd102, 10'd50, 7'h41, 4'd0,  1'b0};
    vecs[3]  = '{10'd107, 10'd50, 7'h41, 4'd0,  1'b1};
    vecs[4]  = '{10'd107, 10'd51, 7'h41, 4'd1,  1'b0};
    vecs[5]  = '{10'd104, 10'd59, 7'h41, 4'd9,  1'b1};
    vecs[6]  = '{10'd108, 10'd50, 7'h20, 4'd0,  1'b0};
    vecs[7]  = '{10'd99,  10'd50, 7'h20, 4'd0,  1'b0};
    vecs[8]  = '{10'd100, 10'd49, 7'h41, 4'd15, 1'b0};
    vecs[9]  = '{10'd228, 10'd50, 7'h41, 4'd0,  1'b0};
    vecs[10] = '{10'd100, 10'd66, 7'h41, 4'd0,  1'b0};
    vecs[11] = '{10'd100, 10'd65, 7'h41, 4'd15, 1'b1};

    rst_n = 1'b0;
    wr_valid = 1'b0; wr_cmd = 2'b00; wr_char = 7'h00;
    frame_start = 1'b0; pos_x = '0; pos_y = '0;
    pixel_x = '0; pixel_y = '0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cursor", 32'(cursor_pos), 32'd0);
    chk("rst_rom_char", 32'(rom_char), 32'h20);
    chk("rst_rom_row", 32'(rom_row), 32'd0);
    chk("rst_on", 32'(text_bit_on), 32'd0);
    rst_n = 1'b1;
    tick();

    // Blank line: no pixels on rows 0..14, underline blinks on cell 0 row 15
    frame(10'd100, 10'd50);
    tick(); tick(); tick();
    ones = 0;
    for (int y = 50; y < 65; y++) begin
      for (int x = 100; x < 228; x++) begin
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        tick();
        if (text_bit_on) ones++;
      end
    end
    pixel_x = '0; pixel_y = '0;
    tick(); if (text_bit_on) ones++;
    tick(); if (text_bit_on) ones++;
    chk("blank_scan_ones", 32'(ones), 32'd0);
    hold_count(10'd100, 10'd65, 2 * BLINK_DIV, ones);
    chk("underline_cell0_ones", 32'(ones), 32'(BLINK_DIV));
    hold_count(10'd108, 10'd65, 2 * BLINK_DIV, ones);
    chk("underline_cell1_ones", 32'(ones), 32'd0);

    // PUT 'A' then pipelined table; rom_* after 1 edge, text_bit_on after 2
    send(2'b00, 7'h41);
    chk("put_a_cursor", 32'(cursor_pos), 32'd1);
    for (int i = 0; i <= 12; i++) begin
      if (i < 12) begin
        pixel_x = vecs[i].px;
        pixel_y = vecs[i].py;
      end
      tick();
      if (i < 12) begin
        chk($sformatf("vec%0d_char", i), 32'(rom_char), 32'(vecs[i].exp_char));
        chk($sformatf("vec%0d_row", i), 32'(rom_row), 32'(vecs[i].exp_row));
      end
      if (i >= 1)
        chk($sformatf("vec%0d_on", i - 1), 32'(text_bit_on), 32'(vecs[i-1].exp_on));
    end

    // Cursor saturation, backspace and set-cursor
    send(2'b11, 7'h00);
    for (int i = 0; i < 16; i++) send(2'b00, 7'h42);
    chk("put16_cursor", 32'(cursor_pos), 32'd15);
    send(2'b00, 7'h42);
    chk("put17_cursor", 32'(cursor_pos), 32'd15);
    render("cell15_b", 10'd220, 10'd50, 7'h42, 4'd0, 1'b1);
    send(2'b01, 7'h00);
    chk("bksp_cursor", 32'(cursor_pos), 32'd14);
    render("cell14_sp", 10'd212, 10'd50, 7'h20, 4'd0, 1'b0);
    render("cell15_keep", 10'd220, 10'd50, 7'h42, 4'd0, 1'b1);
    send(2'b11, 7'h09);
    chk("setc_cursor", 32'(cursor_pos), 32'd9);
    render("cell9_keep", 10'd172, 10'd50, 7'h42, 4'd0, 1'b1);
    send(2'b11, 7'h00);
    send(2'b01, 7'h00);
    chk("bksp0_cursor", 32'(cursor_pos), 32'd0);
    render("cell0_keep", 10'd100, 10'd50, 7'h42, 4'd0, 1'b1);

    // CLEAR timing with a PUT held during the sweep
    begin
      bit ok = 1'b0;
      wr_valid = 1'b1;
      wr_cmd = 2'b10;
      wr_char = 7'h00;
      for (int k = 0; k < 64 && !ok; k++) begin
        @(negedge clk);
        if (wr_ready) ok = 1'b1;
        tick();
      end
      chk("clear_accept", 32'(ok), 32'd1);
      wr_cmd = 2'b00;
      wr_char = 7'h5A;
      for (int c = 1; c <= 16; c++) begin
        chk($sformatf("clr_ready_t%0d", c), 32'(wr_ready), 32'd0);
        chk($sformatf("clr_busy_t%0d", c), 32'(busy), 32'd1);
        tick();
      end
      chk("clr_ready_t17", 32'(wr_ready), 32'd1);
      chk("clr_busy_t17", 32'(busy), 32'd0);
      chk("clr_cursor_t17", 32'(cursor_pos), 32'd0);
      tick();
      wr_valid = 1'b0;
      chk("held_put_cursor", 32'(cursor_pos), 32'd1);
    end
    render("clr_cell0_z", 10'd100, 10'd50, 7'h5A, 4'd0, 1'b1);
    for (int c = 1; c < 16; c++)
      render($sformatf("clr_cell%0d", c), 10'(100 + 8 * c), 10'd50, 7'h20, 4'd0, 1'b0);

    // Origin near the right/bottom edge: no wrap to pixel (0,0)
    send(2'b00, 7'h51);
    send(2'b00, 7'h53);
    send(2'b00, 7'h54);
    chk("qst_cursor", 32'(cursor_pos), 32'd4);
    frame(10'd1000, 10'd1015);
    render("edge_1023", 10'd1023, 10'd1015, 7'h53, 4'd0, 1'b1);
    render("edge_0_0", 10'd0, 10'd0, 7'h54, 4'd9, 1'b0);
    pos_x = '0;
    pos_y = '0;
    tick();
    render("origin_held", 10'd1023, 10'd1015, 7'h53, 4'd0, 1'b1);

    // Reset in the middle of a CLEAR sweep
    frame(10'd100, 10'd50);
    pixel_x = 10'd124;
    pixel_y = 10'd55;
    tick(); tick(); tick();
    send(2'b10, 7'h00);
    tick(); tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_char", 32'(rom_char), 32'h54);
    chk("pre_rst_on", 32'(text_bit_on), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(wr_ready), 32'd1);
    chk("mid_rst_cursor", 32'(cursor_pos), 32'd0);
    chk("mid_rst_char", 32'(rom_char), 32'h20);
    chk("mid_rst_row", 32'(rom_row), 32'd0);
    chk("mid_rst_on", 32'(text_bit_on), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    frame(10'd100, 10'd50);
    render("post_rst_cell2", 10'd116, 10'd50, 7'h20, 4'd0, 1'b0);
    render("post_rst_cell3", 10'd124, 10'd50, 7'h20, 4'd0, 1'b0);
    chk("post_rst_ready", 32'(wr_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/text_line_controller.md
TEXT_LINE_CONTROLLER -- requirements
Module: text_line_controller

Interface
REQ-001 Parameter BLINK_DIV, default 25_000_000, clk cycles per cursor blink half-period; legal range 2..2^26-1.
REQ-002 Parameter CURSOR_EN, default 1, 1 = draw blinking underline cursor, 0 = no cursor.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 wr_valid  in  1  command request.
REQ-006 wr_ready  out  1  command accept; a command is taken on a cycle with wr_valid & wr_ready.
REQ-007 wr_cmd  in  2  00 PUT, 01 BACKSPACE, 10 CLEAR, 11 SET_CURSOR.
REQ-008 wr_char  in  7  ASCII for PUT; wr_char[3:0] is the target cell for SET_CURSOR.
REQ-009 frame_start  in  1  one-cycle pulse at start of frame; latches origin.
REQ-010 pos_x, pos_y  in  10 each  requested top-left pixel of the 16-cell line.
REQ-011 pixel_x, pixel_y  in  10 each  current scan position, one pixel per cycle.
REQ-012 rom_char  out  7  character code to external CharRom (combinational ROM).
REQ-013 rom_row  out  4  glyph row to CharRom.
REQ-014 rom_line  in  8  glyph row from CharRom; bit 7 = leftmost pixel.
REQ-015 text_bit_on  out  1  foreground pixel, registered.
REQ-016 cursor_pos  out  4  current cursor cell.
REQ-017 busy  out  1  high while in CLEAR state.

Function
REQ-018 Block SHALL own a 16 x 7-bit character buffer, cells 0..15 left to right, 8x16 px each (line = 128x16 px).
REQ-019 FSM SHALL have states IDLE and CLEAR; wr_ready = 1 in IDLE, 0 in CLEAR; busy = (state == CLEAR).
REQ-020 PUT: buf[cursor] <= wr_char; cursor <= cursor+1, saturating at 15 (no wrap; further PUTs overwrite cell 15).
REQ-021 BACKSPACE: if cursor > 0, cursor <= cursor-1 and buf[cursor-1] <= 0x20; at cursor 0, no change.
REQ-022 SET_CURSOR: cursor <= wr_char[3:0]; buffer unchanged.
REQ-023 CLEAR: on accept, cursor <= 0 and FSM -> CLEAR; a 4-bit counter writes 0x20 to cells 0..15, one per cycle, over exactly 16 cycles; after cell 15 FSM -> IDLE, wr_ready high again on the 17th cycle after accept.
REQ-024 Commands with wr_valid high while wr_ready low SHALL be ignored, not queued; requester holds wr_valid.
REQ-025 On frame_start, origin registers SHALL load pos_x/pos_y; origin is otherwise constant, so mid-frame pos changes have no visible effect.
REQ-026 Stage 1 (registered): in_area = pixel_x >= ox, pixel_x < ox+128, pixel_y >= oy, pixel_y < oy+16, bounds computed 11 bits wide so no wrap above 1023; cell = (pixel_x-ox)[6:3]; bit = (pixel_x-ox)[2:0]; rom_char <= buf[cell]; rom_row <= (pixel_y-oy)[3:0].
REQ-027 Stage 2 (registered): text_bit_on <= in_area_q & (rom_line[7-bit_q] | cur_q), where cur_q = CURSOR_EN & blink & (cell_q == cursor) & (rom_row == 15).
REQ-028 Latency from pixel_x/pixel_y to text_bit_on SHALL be exactly 2 cycles; throughput one pixel per cycle, no stalls.
REQ-029 Blink: counter counts 0..BLINK_DIV-1 and wraps; blink toggles on each wrap.
REQ-030 Buffer writes and render reads in the same cycle: render sees the pre-write value (read-before-write); mid-CLEAR frames show partial clearing.
REQ-031 Outside in_area, text_bit_on SHALL be 0 regardless of buffer content or cursor.

Reset
REQ-032 While reset = 0: state IDLE, all buffer cells 0x20, cursor_pos 0, origin (0,0), blink 0, blink counter 0, rom_char 0x20, rom_row 0, stage registers 0, text_bit_on 0, busy 0, wr_ready 1.
REQ-033 Reset asserted mid-CLEAR SHALL abort the sweep; after release the block is in IDLE with all cells 0x20.

Verification
REQ-034 Reset, frame_start with pos (100,50), scan (100..227, 50..65) -> text_bit_on 0 everywhere (CharRom space blank), except the row-15 underline at cell 0 when blink = 1 and CURSOR_EN = 1.
REQ-035 PUT 'A' (0x41), then scan pixel (100,50+r) -> rom_char 0x41, rom_row r, text_bit_on = rom_line[7] exactly 2 cycles later; cursor_pos 1.
REQ-036 17 PUTs of 'B' -> cursor_pos 15 after the 16th PUT; the 17th PUT leaves cell 15 = 'B' and cursor_pos 15; BACKSPACE -> cursor_pos 14, cell 14 = 0x20.
REQ-037 CLEAR accepted at cycle t -> wr_ready 0 and busy 1 for cycles t+1..t+16, wr_ready 1 at t+17; a PUT held during CLEAR is taken at t+17; all cells 0x20 at t+17.
REQ-038 pos (1000,1015) with frame_start -> pixel (1023,1015) on per glyph, pixel (0,0) never on (no wrap); reset pulsed mid-CLEAR -> all outputs at reset values immediately, without waiting for a clock edge.
